alu_control: RTL and testbench
==============================

ALU_CONTROL -- requirements
Module: alu_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port opcode, input, 6 bits: instruction opcode field.
REQ-004 SHALL have port instructionType, input, 2 bits: 00 R-type, 01 J-type, 10 I-type, 11 S-type (shift).
REQ-005 SHALL have port ALUControl, output, 4 bits: registered ALU operation code.
REQ-006 SHALL have port illegal, output, 1 bit: registered flag, 1 when the {instructionType, opcode} pair is unmapped.
REQ-007 SHALL have no parameters; all widths are fixed.

Function
REQ-008 SHALL use these ALU operation codes: 0000 NOP/default, 0001 AND, 0010 ADD, 0011 SUB, 0100 CMP, 0101 BEQ, 1100 SLL, 1101 SLR, 1110 SLLV, 1111 SLRV; codes 0110-1011 are never produced.
REQ-009 SHALL decode R-type (00) as follows: opcode 0 -> 0001, 1 -> 0010, 2 -> 0011, 3 -> 0100.
REQ-010 SHALL decode I-type (10) as follows: opcode 0 (ANDI) -> 0001, 1 (ADDI) -> 0010, 2 (LW) -> 0010, 3 (SW) -> 0010, 4 (BEQ) -> 0101.
REQ-011 SHALL decode J-type (01) as follows: opcode 0 (J) and 1 (JAL) -> 0000 with illegal=0.
REQ-012 SHALL decode S-type (11) as follows: opcode 0 -> 1100, 1 -> 1101, 2 -> 1110, 3 -> 1111.
REQ-013 SHALL, for any unmapped opcode within any type, produce ALUControl=0000 and illegal=1.
REQ-014 SHALL decode opcode over its full 6 bits; e.g. R-type opcode 6'b100000 is unmapped, not aliased to 0.
REQ-015 SHALL register both outputs on every rising clk edge, giving 1-cycle latency from an input change to the output change.
REQ-016 SHALL treat X/Z on the inputs as unmapped (0000, illegal=1) in simulation; no latches.
REQ-017 SHALL have no enable or handshake; the outputs follow the decode of inputs sampled at each edge.

Reset
REQ-018 SHALL, while rst=1, force ALUControl=0000 and illegal=0 immediately, independent of clk.
REQ-019 SHALL, on rst deassertion, resume decoding at the first rising clk edge; a reset asserted mid-stream discards the pending decode.

Structure
REQ-020 SHALL take the ALU opcode constants (REQ-008) and instruction-type constants (REQ-004) from shared package alu_pkg, which is also used by alu and the datapath muxes.
REQ-021 SHALL place the pure combinational decode in one sub-module, alu_op_decode; alu_control adds only the output register.

Verification
REQ-022 SHALL verify: rst=1 with instructionType=00, opcode=1 -> ALUControl=0000, illegal=0 with no clock edge required.
REQ-023 SHALL verify: R-type sweep of opcodes 0..3 -> 0001, 0010, 0011, 0100, each appearing one edge after it is applied; opcode 4 -> 0000, illegal=1.
REQ-024 SHALL verify: I-type sweep of opcodes 0..4 -> 0001, 0010, 0010, 0010, 0101; opcode 5 -> illegal=1.
REQ-025 SHALL verify: S-type sweep of opcodes 0..3 -> 1100, 1101, 1110, 1111; J-type opcode 0 -> 0000, illegal=0.
REQ-026 SHALL verify: S-type opcode 2 applied with rst pulsed between edges -> output 0000 during reset, then 1110 at the first edge after release.
REQ-027 SHALL verify: R-type opcode 6'b100011 -> 0000, illegal=1 (upper bits not ignored).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: instruction-type encodings, ALU operation codes
// and the decode result record used by the control path and datapath muxes.
package alu_pkg;

  typedef enum logic [1:0] {
    ITYPE_R = 2'b00,
    ITYPE_J = 2'b01,
    ITYPE_I = 2'b10,
    ITYPE_S = 2'b11
  } instr_type_e;

  // Codes 0110-1011 are reserved and never produced by the decoder.
  typedef enum logic [3:0] {
    ALU_NOP  = 4'b0000,
    ALU_AND  = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0011,
    ALU_CMP  = 4'b0100,
    ALU_BEQ  = 4'b0101,
    ALU_SLL  = 4'b1100,
    ALU_SLR  = 4'b1101,
    ALU_SLLV = 4'b1110,
    ALU_SLRV = 4'b1111
  } alu_op_e;

  typedef struct packed {
    alu_op_e op;
    logic    illegal;
  } alu_decode_t;

  localparam alu_decode_t UNMAPPED = '{op: ALU_NOP, illegal: 1'b1};

  function automatic alu_decode_t mapped(input alu_op_e op);
    return '{op: op, illegal: 1'b0};
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Pure combinational decode of {instruction type, opcode} into an ALU
// operation code plus an illegal flag for unmapped pairs.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] instr_type_i,
  input  logic [5:0] opcode_i,
  output logic [3:0] alu_ctrl_o,
  output logic       illegal_o
);

  alu_decode_t dec;

  // Full 6-bit opcode match per type; anything unmatched (including X/Z
  // inputs in 4-state simulation) falls through to the unmapped result.
  always_comb begin
    dec = UNMAPPED;
    case (instr_type_i)
      ITYPE_R: begin
        case (opcode_i)
          6'd0:    dec = mapped(ALU_AND);
          6'd1:    dec = mapped(ALU_ADD);
          6'd2:    dec = mapped(ALU_SUB);
          6'd3:    dec = mapped(ALU_CMP);
          default: dec = UNMAPPED;
        endcase
      end
      ITYPE_J: begin
        case (opcode_i)
          6'd0:    dec = mapped(ALU_NOP);  // J
          6'd1:    dec = mapped(ALU_NOP);  // JAL
          default: dec = UNMAPPED;
        endcase
      end
      ITYPE_I: begin
        case (opcode_i)
          6'd0:    dec = mapped(ALU_AND);  // ANDI
          6'd1:    dec = mapped(ALU_ADD);  // ADDI
          6'd2:    dec = mapped(ALU_ADD);  // LW address
          6'd3:    dec = mapped(ALU_ADD);  // SW address
          6'd4:    dec = mapped(ALU_BEQ);  // BEQ
          default: dec = UNMAPPED;
        endcase
      end
      ITYPE_S: begin
        case (opcode_i)
          6'd0:    dec = mapped(ALU_SLL);
          6'd1:    dec = mapped(ALU_SLR);
          6'd2:    dec = mapped(ALU_SLLV);
          6'd3:    dec = mapped(ALU_SLRV);
          default: dec = UNMAPPED;
        endcase
      end
      default: dec = UNMAPPED;
    endcase
  end

  assign alu_ctrl_o = dec.op;
  assign illegal_o  = dec.illegal;

endmodule

// File: rtl/alu_control.sv
// ALU control unit: registers the combinational opcode decode, giving a
// one-cycle latency from inputs to ALUControl/illegal.
module alu_control
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [1:0] instructionType,
  output logic [3:0] ALUControl,
  output logic       illegal
);

  logic [3:0] alu_ctrl_d;
  logic [3:0] alu_ctrl_q;
  logic       illegal_d;
  logic       illegal_q;

  alu_op_decode u_decode (
    .instr_type_i (instructionType),
    .opcode_i     (opcode),
    .alu_ctrl_o   (alu_ctrl_d),
    .illegal_o    (illegal_d)
  );

  // Output register; reset forces NOP/legal immediately and drops any pending decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_ctrl_q <= ALU_NOP;
      illegal_q  <= 1'b0;
    end else begin
      alu_ctrl_q <= alu_ctrl_d;
      illegal_q  <= illegal_d;
    end
  end

  assign ALUControl = alu_ctrl_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_control.sv
// Directed bench for alu_control: reset behaviour, per-type opcode sweeps
// with one-edge latency, full-width opcode decode and mid-stream reset.
module tb_alu_control;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [1:0] instructionType;
  logic [3:0] ALUControl;
  logic       illegal;

  int errors = 0;
  int checks = 0;

  // Bench-tracked expected register contents (what the DUT should hold now).
  logic [3:0] exp_ctrl;
  logic       exp_ill;

  typedef struct {
    logic [1:0] t;
    logic [5:0] op;
    logic [3:0] ctrl;
    logic       ill;
  } vec_t;

  alu_control dut (
    .clk             (clk),
    .rst             (rst),
    .opcode          (opcode),
    .instructionType (instructionType),
    .ALUControl      (ALUControl),
    .illegal         (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    rst = 1'b1;
    instructionType = 2'b00;
    opcode = 6'd1;
    #2;
    checks++;
    if (ALUControl !== 4'b0000 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got ctrl=%b ill=%b expected ctrl=0000 ill=0", ALUControl, illegal);
    end
    @(posedge clk); #1;
    checks++;
    if (ALUControl !== 4'b0000 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_held_edge: got ctrl=%b ill=%b expected ctrl=0000 ill=0", ALUControl, illegal);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ALUControl !== 4'b0000 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_noedge: got ctrl=%b ill=%b expected ctrl=0000 ill=0", ALUControl, illegal);
    end
    exp_ctrl = 4'b0000;
    exp_ill  = 1'b0;
  endtask

  task automatic test_rtype;
    vec_t v [5];
    v = '{'{2'b00, 6'd0, 4'b0001, 1'b0},
          '{2'b00, 6'd1, 4'b0010, 1'b0},
          '{2'b00, 6'd2, 4'b0011, 1'b0},
          '{2'b00, 6'd3, 4'b0100, 1'b0},
          '{2'b00, 6'd4, 4'b0000, 1'b1}};
    for (int i = 0; i < 5; i++) begin
      instructionType = v[i].t;
      opcode = v[i].op;
      #1;
      checks++;
      if (ALUControl !== exp_ctrl || illegal !== exp_ill) begin
        errors++;
        $display("FAIL rtype_hold[%0d]: got ctrl=%b ill=%b expected ctrl=%b ill=%b", i, ALUControl, illegal, exp_ctrl, exp_ill);
      end
      @(posedge clk); #1;
      checks++;
      if (ALUControl !== v[i].ctrl || illegal !== v[i].ill) begin
        errors++;
        $display("FAIL rtype[%0d]: got ctrl=%b ill=%b expected ctrl=%b ill=%b", i, ALUControl, illegal, v[i].ctrl, v[i].ill);
      end
      exp_ctrl = v[i].ctrl;
      exp_ill  = v[i].ill;
    end
  endtask

  task automatic test_itype;
    vec_t v [7];
    v = '{'{2'b10, 6'd0, 4'b0001, 1'b0},
          '{2'b10, 6'd1, 4'b0010, 1'b0},
          '{2'b10, 6'd2, 4'b0010, 1'b0},
          '{2'b10, 6'd3, 4'b0010, 1'b0},
          '{2'b10, 6'd4, 4'b0101, 1'b0},
          '{2'b10, 6'd5, 4'b0000, 1'b1},
          '{2'b10, 6'd63, 4'b0000, 1'b1}};
    for (int i = 0; i < 7; i++) begin
      instructionType = v[i].t;
      opcode = v[i].op;
      @(posedge clk); #1;
      checks++;
      if (ALUControl !== v[i].ctrl || illegal !== v[i].ill) begin
        errors++;
        $display("FAIL itype[%0d]: got ctrl=%b ill=%b expected ctrl=%b ill=%b", i, ALUControl, illegal, v[i].ctrl, v[i].ill);
      end
    end
    exp_ctrl = v[6].ctrl;
    exp_ill  = v[6].ill;
  endtask

  task automatic test_stype_jtype;
    vec_t v [8];
    v = '{'{2'b11, 6'd0, 4'b1100, 1'b0},
          '{2'b11, 6'd1, 4'b1101, 1'b0},
          '{2'b11, 6'd2, 4'b1110, 1'b0},
          '{2'b11, 6'd3, 4'b1111, 1'b0},
          '{2'b11, 6'd4, 4'b0000, 1'b1},
          '{2'b01, 6'd0, 4'b0000, 1'b0},
          '{2'b01, 6'd1, 4'b0000, 1'b0},
          '{2'b01, 6'd2, 4'b0000, 1'b1}};
    for (int i = 0; i < 8; i++) begin
      instructionType = v[i].t;
      opcode = v[i].op;
      @(posedge clk); #1;
      checks++;
      if (ALUControl !== v[i].ctrl || illegal !== v[i].ill) begin
        errors++;
        $display("FAIL sjtype[%0d]: got ctrl=%b ill=%b expected ctrl=%b ill=%b", i, ALUControl, illegal, v[i].ctrl, v[i].ill);
      end
    end
    exp_ctrl = v[7].ctrl;
    exp_ill  = v[7].ill;
  endtask

  task automatic test_upper_bits;
    vec_t v [5];
    v = '{'{2'b00, 6'b100011, 4'b0000, 1'b1},
          '{2'b00, 6'b000011, 4'b0100, 1'b0},
          '{2'b00, 6'b100000, 4'b0000, 1'b1},
          '{2'b11, 6'b010010, 4'b0000, 1'b1},
          '{2'b10, 6'b100100, 4'b0000, 1'b1}};
    for (int i = 0; i < 5; i++) begin
      instructionType = v[i].t;
      opcode = v[i].op;
      @(posedge clk); #1;
      checks++;
      if (ALUControl !== v[i].ctrl || illegal !== v[i].ill) begin
        errors++;
        $display("FAIL upper_bits[%0d]: got ctrl=%b ill=%b expected ctrl=%b ill=%b", i, ALUControl, illegal, v[i].ctrl, v[i].ill);
      end
    end
    exp_ctrl = v[4].ctrl;
    exp_ill  = v[4].ill;
  endtask

  task automatic test_reset_midstream;
    // Load a non-zero value first so the reset effect is visible.
    instructionType = 2'b00;
    opcode = 6'd0;
    @(posedge clk); #1;
    checks++;
    if (ALUControl !== 4'b0001 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL mid_preload: got ctrl=%b ill=%b expected ctrl=0001 ill=0", ALUControl, illegal);
    end
    instructionType = 2'b11;
    opcode = 6'd2;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (ALUControl !== 4'b0000 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL mid_during_reset: got ctrl=%b ill=%b expected ctrl=0000 ill=0", ALUControl, illegal);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (ALUControl !== 4'b0000 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL mid_after_release: got ctrl=%b ill=%b expected ctrl=0000 ill=0", ALUControl, illegal);
    end
    @(posedge clk); #1;
    checks++;
    if (ALUControl !== 4'b1110 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL mid_first_edge: got ctrl=%b ill=%b expected ctrl=1110 ill=0", ALUControl, illegal);
    end
    // Reset spanning an edge discards the decode presented at that edge.
    instructionType = 2'b00;
    opcode = 6'd9;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ALUControl !== 4'b0000 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL mid_span_edge: got ctrl=%b ill=%b expected ctrl=0000 ill=0", ALUControl, illegal);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ALUControl !== 4'b0000 || illegal !== 1'b1) begin
      errors++;
      $display("FAIL mid_resume_illegal: got ctrl=%b ill=%b expected ctrl=0000 ill=1", ALUControl, illegal);
    end
    exp_ctrl = 4'b0000;
    exp_ill  = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_stype_jtype();
    test_upper_bits();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
